// File: rtl/phase_seq_if.sv
// Control and status bundle between the core's control logic and the phase sequencer.
interface phase_seq_if #(
  parameter int NPH   = 5,
  parameter int CNT_W = 16
);
  logic             hlt;
  logic             stall;
  logic             resume;
  logic             step_mode;
  logic             step;
  logic [NPH-1:0]   phase;
  logic             last;
  logic             running;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output hlt, stall, resume, step_mode, step,
    input  phase, last, running, instr_cnt
  );

  modport slave (
    input  hlt, stall, resume, step_mode, step,
    output phase, last, running, instr_cnt
  );
endinterface

// File: rtl/phase_seq.sv
// One-hot instruction-phase sequencer with start-up delay, stall hold, HLT parking,
// single-step mode and a wrapping completed-instruction counter.
module phase_seq #(
  parameter int NPH       = 5,
  parameter int START_DLY = 2,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  phase_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_STEP = 2'd3
  } state_t;

  localparam logic [NPH-1:0]   PH_ZERO  = {NPH{1'b0}};
  localparam logic [NPH-1:0]   PH_FIRST = {{(NPH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       DLY_LAST = 4'(START_DLY - 1);

  state_t           state_q, state_d;
  logic [3:0]       dly_q, dly_d;
  logic [NPH-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;

  // Next-state, phase and counter computation.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        if (dly_q == DLY_LAST) begin
          state_d = S_RUN;
          phase_d = PH_FIRST;
        end else begin
          dly_d   = dly_q + 4'd1;
          phase_d = PH_ZERO;
        end
      end
      S_RUN: begin
        if (bus.hlt) begin
          // abandoned instruction is not counted
          state_d = S_HALT;
          phase_d = PH_ZERO;
        end else if (bus.stall) begin
          phase_d = phase_q;
        end else if (phase_q[NPH-1]) begin
          cnt_d = cnt_q + CNT_ONE;
          if (bus.step_mode) begin
            state_d = S_STEP;
            phase_d = PH_ZERO;
          end else begin
            phase_d = PH_FIRST;
          end
        end else begin
          phase_d = {phase_q[NPH-2:0], 1'b0};
        end
      end
      S_HALT: begin
        if (bus.resume && !bus.hlt) begin
          state_d = S_RUN;
          phase_d = PH_FIRST;
        end else begin
          phase_d = PH_ZERO;
        end
      end
      S_STEP: begin
        if (bus.hlt) begin
          state_d = S_HALT;
          phase_d = PH_ZERO;
        end else if (bus.step || !bus.step_mode) begin
          state_d = S_RUN;
          phase_d = PH_FIRST;
        end else begin
          phase_d = PH_ZERO;
        end
      end
      default: begin
        state_d = S_WAIT;
        dly_d   = 4'd0;
        phase_d = PH_ZERO;
      end
    endcase
    running_d = (state_d == S_RUN);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= S_WAIT;
      dly_q     <= 4'd0;
      phase_q   <= PH_ZERO;
      cnt_q     <= {CNT_W{1'b0}};
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.running   = running_q;
  assign bus.instr_cnt = cnt_q;
  assign bus.last      = phase_q[NPH-1] & ~bus.stall;

endmodule

// File: tb/tb_phase_seq.sv
// Randomized check of two phase_seq configurations against a mode/phase-index reference model.
module tb_phase_seq;

  localparam int NPH_A = 5, DLY_A = 2, CW_A = 16;
  localparam int NPH_B = 2, DLY_B = 3, CW_B = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic hlt = 1'b0, stall = 1'b0, resume = 1'b0, step_mode = 1'b0, step = 1'b0;

  int total = 0;
  int bad   = 0;

  phase_seq_if #(.NPH(NPH_A), .CNT_W(CW_A)) ifa ();
  phase_seq_if #(.NPH(NPH_B), .CNT_W(CW_B)) ifb ();

  assign ifa.hlt = hlt;  assign ifa.stall = stall;  assign ifa.resume = resume;
  assign ifa.step_mode = step_mode;  assign ifa.step = step;
  assign ifb.hlt = hlt;  assign ifb.stall = stall;  assign ifb.resume = resume;
  assign ifb.step_mode = step_mode;  assign ifb.step = step;

  phase_seq #(.NPH(NPH_A), .START_DLY(DLY_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(ifa.slave));
  phase_seq #(.NPH(NPH_B), .START_DLY(DLY_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=wait 1=run 2=halt 3=step; idx = active phase number.
  int     m_mode[2], m_wait[2], m_idx[2];
  longint m_cnt[2];
  int     k_nph[2] = '{NPH_A, NPH_B};
  int     k_dly[2] = '{DLY_A, DLY_B};
  int     k_cw[2]  = '{CW_A, CW_B};

  function automatic void model_step(input int k);
    if (!n_rst) begin
      m_mode[k] = 0; m_wait[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
    end else if (m_mode[k] == 0) begin
      if (m_wait[k] == k_dly[k] - 1) begin m_mode[k] = 1; m_idx[k] = 0; end
      else m_wait[k]++;
    end else if (m_mode[k] == 1) begin
      if (hlt) m_mode[k] = 2;
      else if (!stall) begin
        if (m_idx[k] == k_nph[k] - 1) begin
          m_cnt[k] = (m_cnt[k] + 1) % (longint'(1) << k_cw[k]);
          if (step_mode) m_mode[k] = 3;
          else m_idx[k] = 0;
        end else m_idx[k]++;
      end
    end else if (m_mode[k] == 2) begin
      if (resume && !hlt) begin m_mode[k] = 1; m_idx[k] = 0; end
    end else begin
      if (hlt) m_mode[k] = 2;
      else if (step || !step_mode) begin m_mode[k] = 1; m_idx[k] = 0; end
    end
  endfunction

  function automatic longint exp_phase(input int k);
    return (m_mode[k] == 1) ? (longint'(1) << m_idx[k]) : 0;
  endfunction

  function automatic longint exp_last(input int k);
    return (m_mode[k] == 1 && m_idx[k] == k_nph[k] - 1 && !stall) ? 1 : 0;
  endfunction

  // Advance the model on each edge and compare both DUTs just after it.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    chk("a_phase",   longint'(ifa.phase),     exp_phase(0));
    chk("a_last",    longint'(ifa.last),      exp_last(0));
    chk("a_running", longint'(ifa.running),   (m_mode[0] == 1) ? 1 : 0);
    chk("a_cnt",     longint'(ifa.instr_cnt), m_cnt[0]);
    chk("b_phase",   longint'(ifb.phase),     exp_phase(1));
    chk("b_last",    longint'(ifb.last),      exp_last(1));
    chk("b_running", longint'(ifb.running),   (m_mode[1] == 1) ? 1 : 0);
    chk("b_cnt",     longint'(ifb.instr_cnt), m_cnt[1]);
  end

  int a_seq[7] = '{0, 1, 2, 4, 8, 16, 1};

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_phase", longint'(ifa.phase), 0);
    chk("rst_cnt",   longint'(ifa.instr_cnt), 0);
    chk("rst_run",   longint'(ifa.running), 0);
    @(negedge clk);
    n_rst = 1'b1;
    // Edge k below is E0+k; hand-computed startup, wrap and counter-overflow values.
    for (int k = 0; k < 37; k++) begin
      @(posedge clk);
      #2;
      if (k < 7) chk("start_seq", longint'(ifa.phase), a_seq[k]);
      if (k == 5) chk("last_at_16", longint'(ifa.last), 1);
      if (k == 6) chk("cnt_first_wrap", longint'(ifa.instr_cnt), 1);
      if (k == 1) chk("b_start", longint'(ifb.phase), 0);
      if (k == 2) chk("b_first", longint'(ifb.phase), 1);
      if (k == 3) chk("b_second", longint'(ifb.phase), 2);
      if (k == 32) chk("b_cnt15", longint'(ifb.instr_cnt), 15);
      if (k == 34) chk("b_cnt_wrap0", longint'(ifb.instr_cnt), 0);
      if (k == 36) chk("b_cnt_wrap1", longint'(ifb.instr_cnt), 1);
      if (k == 36) chk("a_cnt7", longint'(ifa.instr_cnt), 7);
    end
    // Randomized control traffic, including occasional mid-run resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      n_rst  = ($urandom_range(0, 249) != 0);
      hlt    = ($urandom_range(0, 24) == 0);
      stall  = ($urandom_range(0, 4) == 0);
      resume = ($urandom_range(0, 5) == 0);
      step   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
